// File: rtl/sad_pkg.sv
// Shared definitions for the block SAD datapath and controller.
// Holds the lane count, the FSM state type and the result-width helper.
package sad_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  // Result width that holds LANES*beats worst-case |cur-ref| terms without overflow.
  function automatic int sad_width(input int pix_w, input int beats);
    return pix_w + $clog2(LANES * beats);
  endfunction

endpackage

// File: rtl/sad_lane_reducer.sv
// Combinational beat reducer: four |cur-ref| units, a 4:2 compressor row, one carry-propagate add.
// Zero latency; no flow control of its own (the controller decides when the beat sum is used).
module sad_lane_reducer
  import sad_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [LANES*PIX_W-1:0] cur_pix,
  input  logic [LANES*PIX_W-1:0] ref_pix,
  output logic [PIX_W+1:0]       beat_sum
);

  localparam int W = PIX_W + 2;

  logic [PIX_W:0] diff [LANES];
  logic [W-1:0]   absd [LANES];
  logic [W-1:0]   s1, c1, s2, c2;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      diff[k] = {1'b0, cur_pix[k*PIX_W +: PIX_W]} - {1'b0, ref_pix[k*PIX_W +: PIX_W]};
      absd[k] = {1'b0, diff[k][PIX_W] ? -diff[k] : diff[k]};
    end
  end

  // Two 3:2 stages form the 4:2 row; carries dropped off the top are harmless
  // because the true sum always fits in W bits, so the modular result is exact.
  assign s1 = absd[0] ^ absd[1] ^ absd[2];
  assign c1 = ((absd[0] & absd[1]) | (absd[0] & absd[2]) | (absd[1] & absd[2])) << 1;
  assign s2 = s1 ^ c1 ^ absd[3];
  assign c2 = ((s1 & c1) | (s1 & absd[3]) | (c1 & absd[3])) << 1;

  assign beat_sum = s2 + c2;

endmodule

// File: rtl/sad_block_controller.sv
// Block SAD sequencer: accumulates BLOCK_BEATS 4-lane beats, result valid 1 cycle after the last beat;
// holds the result until sad_ready. Optional min tracker under macro SAD_MIN_TRACK_EN.
module sad_block_controller
  import sad_pkg::*;
#(
  parameter int  PIX_W       = 8,
  parameter int  BLOCK_BEATS = 16,
  localparam int SAD_W       = sad_width(PIX_W, BLOCK_BEATS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*PIX_W-1:0] cur_pix,
  input  logic [LANES*PIX_W-1:0] ref_pix,
  output logic                   sad_valid,
  input  logic                   sad_ready,
`ifdef SAD_MIN_TRACK_EN
  input  logic                   clear_min,
  output logic [SAD_W-1:0]       min_sad,
  output logic [7:0]             min_idx,
  output logic [SAD_W-1:0]       sad_out
`else
  output logic [SAD_W-1:0]       sad_out
`endif
);

  localparam int CNT_W  = $clog2(BLOCK_BEATS);
  localparam int BSUM_W = PIX_W + 2;

  state_t            state;
  logic [SAD_W-1:0]  acc;
  logic [SAD_W-1:0]  acc_next;
  logic [CNT_W-1:0]  beat_cnt;
  logic [BSUM_W-1:0] beat_sum;
  logic              last_beat;

  sad_lane_reducer #(
    .PIX_W(PIX_W)
  ) u_reducer (
    .cur_pix (cur_pix),
    .ref_pix (ref_pix),
    .beat_sum(beat_sum)
  );

  assign acc_next  = acc + SAD_W'(beat_sum);
  assign last_beat = (beat_cnt == CNT_W'(BLOCK_BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      beat_cnt  <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      sad_valid <= 1'b0;
      sad_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACCUM;
            acc      <= '0;
            beat_cnt <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        ACCUM: begin
          if (in_valid && in_ready) begin
            acc <= acc_next;
            if (last_beat) begin
              // Result is loaded with the final beat folded in, so it is valid next cycle.
              state     <= DONE;
              beat_cnt  <= '0;
              in_ready  <= 1'b0;
              sad_valid <= 1'b1;
              sad_out   <= acc_next;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (sad_ready) begin
            sad_valid <= 1'b0;
            if (start) begin
              state    <= ACCUM;
              acc      <= '0;
              beat_cnt <= '0;
              in_ready <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          sad_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SAD_MIN_TRACK_EN
  logic [7:0] cand_idx;

  // Strict compare keeps the earlier candidate on ties; clear beats a same-cycle handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_sad  <= '1;
      min_idx  <= '0;
      cand_idx <= '0;
    end else if (clear_min) begin
      min_sad  <= '1;
      min_idx  <= '0;
      cand_idx <= '0;
    end else if (sad_valid && sad_ready) begin
      cand_idx <= cand_idx + 8'd1;
      if (sad_out < min_sad) begin
        min_sad <= sad_out;
        min_idx <= cand_idx;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sad_block_controller.sv
// Self-checking bench for sad_block_controller against a plain-arithmetic SAD model.
// Min-tracker scenario is compiled in when SAD_MIN_TRACK_EN is defined.
module tb_sad_block_controller;

  localparam int PIX_W = 8;
  localparam int BB    = 16;
  localparam int SAD_W = PIX_W + $clog2(4 * BB);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      cur_pix;
  logic [31:0]      ref_pix;
  logic             sad_valid;
  logic             sad_ready;
  logic [SAD_W-1:0] sad_out;
`ifdef SAD_MIN_TRACK_EN
  logic             clear_min;
  logic [SAD_W-1:0] min_sad;
  logic [7:0]       min_idx;
`endif

  int tests = 0;
  int fails = 0;
  int cur_b[BB][4];
  int ref_b[BB][4];

  always #5 clk = ~clk;

  sad_block_controller #(
    .PIX_W      (PIX_W),
    .BLOCK_BEATS(BB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cur_pix  (cur_pix),
    .ref_pix  (ref_pix),
    .sad_valid(sad_valid),
    .sad_ready(sad_ready),
`ifdef SAD_MIN_TRACK_EN
    .clear_min(clear_min),
    .min_sad  (min_sad),
    .min_idx  (min_idx),
`endif
    .sad_out  (sad_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_sad();
    int s = 0;
    for (int b = 0; b < BB; b++)
      for (int k = 0; k < 4; k++)
        s += (cur_b[b][k] > ref_b[b][k]) ? cur_b[b][k] - ref_b[b][k] : ref_b[b][k] - cur_b[b][k];
    return s;
  endfunction

  task automatic fill_random();
    for (int b = 0; b < BB; b++)
      for (int k = 0; k < 4; k++) begin
        cur_b[b][k] = $urandom_range(255);
        ref_b[b][k] = $urandom_range(255);
      end
  endtask

  task automatic fill_target(input int t);
    int rem = t;
    for (int b = 0; b < BB; b++)
      for (int k = 0; k < 4; k++) begin
        int v = (rem > 255) ? 255 : rem;
        rem -= v;
        if ($urandom_range(1) == 1) begin cur_b[b][k] = v; ref_b[b][k] = 0; end
        else begin cur_b[b][k] = 0; ref_b[b][k] = v; end
      end
  endtask

  task automatic drive_beat(input int b);
    for (int k = 0; k < 4; k++) begin
      cur_pix[k*8 +: 8] = 8'(cur_b[b][k]);
      ref_pix[k*8 +: 8] = 8'(ref_b[b][k]);
    end
  endtask

  // Feeds one block; reports sad_valid just before and just after the final accepted beat.
  task automatic feed_block(input bit do_start, input int gap_pct, input int start_pct,
                            output logic pre_v, output logic post_v);
    pre_v = 1'bx;
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int b = 0; b < BB; b++) begin
      int g = 0;
      while (g < 3 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        cur_pix  = $urandom;
        ref_pix  = $urandom;
        start    = ($urandom_range(99) < start_pct);
        tick();
        g++;
      end
      in_valid = 1'b1;
      drive_beat(b);
      start = ($urandom_range(99) < start_pct);
      if (b == BB - 1) pre_v = sad_valid;
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b0;
    post_v   = sad_valid;
  endtask

  task automatic handshake(input bit next_start);
    sad_ready = 1'b1;
    start     = next_start;
    tick();
    sad_ready = 1'b0;
    start     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; sad_ready = 1'b0;
    cur_pix = '0; ref_pix = '0;
`ifdef SAD_MIN_TRACK_EN
    clear_min = 1'b0;
`endif
    tick(); tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tests++; if (sad_valid !== 1'b0) begin fails++; $display("FAIL reset_sad_valid: got %b want 0", sad_valid); end
    tests++; if (sad_out !== '0) begin fails++; $display("FAIL reset_sad_out: got %0d want 0", sad_out); end
`ifdef SAD_MIN_TRACK_EN
    tests++; if (min_sad !== '1) begin fails++; $display("FAIL reset_min_sad: got %0d want all-ones", min_sad); end
    tests++; if (min_idx !== 8'd0) begin fails++; $display("FAIL reset_min_idx: got %0d want 0", min_idx); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_scale();
    logic pre_v, post_v;
    int exp;
    for (int b = 0; b < BB; b++)
      for (int k = 0; k < 4; k++) begin cur_b[b][k] = 255; ref_b[b][k] = 0; end
    exp = model_sad();
    feed_block(1'b1, 0, 0, pre_v, post_v);
    tests++; if (pre_v !== 1'b0) begin fails++; $display("FAIL full_pre_valid: got %b want 0", pre_v); end
    tests++; if (post_v !== 1'b1) begin fails++; $display("FAIL full_latency: got %b want 1", post_v); end
    tests++; if (sad_out !== SAD_W'(exp)) begin fails++; $display("FAIL full_sad: got %0d want %0d", sad_out, exp); end
    tests++; if (busy !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL full_done_flags: busy=%b in_ready=%b want 1/0", busy, in_ready); end
    handshake(1'b0);
    tests++; if (sad_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL full_to_idle: sad_valid=%b busy=%b want 0/0", sad_valid, busy); end
  endtask

  task automatic test_gaps();
    logic pre_v, post_v;
    int exp;
    int cl[4] = '{10, 20, 30, 40};
    int rl[4] = '{40, 30, 20, 10};
    for (int b = 0; b < BB; b++)
      for (int k = 0; k < 4; k++) begin cur_b[b][k] = cl[k]; ref_b[b][k] = rl[k]; end
    exp = model_sad();
    feed_block(1'b1, 40, 0, pre_v, post_v);
    tests++; if (post_v !== 1'b1) begin fails++; $display("FAIL gaps_valid: got %b want 1", post_v); end
    tests++; if (sad_out !== SAD_W'(exp)) begin fails++; $display("FAIL gaps_sad: got %0d want %0d", sad_out, exp); end
    handshake(1'b0);
  endtask

  task automatic test_hold_back_to_back();
    logic pre_v, post_v;
    int exp1, exp2;
    fill_random();
    exp1 = model_sad();
    feed_block(1'b1, 20, 0, pre_v, post_v);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; cur_pix = $urandom; ref_pix = $urandom;
      start = $urandom_range(1);
      tick();
      tests++; if (sad_out !== SAD_W'(exp1) || sad_valid !== 1'b1) begin fails++; $display("FAIL hold_sad: got %0d/%b want %0d/1", sad_out, sad_valid, exp1); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL hold_in_ready: got %b want 0", in_ready); end
    end
    in_valid = 1'b0;
    fill_random();
    exp2 = model_sad();
    handshake(1'b1);
    tests++; if (in_ready !== 1'b1 || busy !== 1'b1 || sad_valid !== 1'b0) begin fails++; $display("FAIL b2b_restart: in_ready=%b busy=%b sad_valid=%b want 1/1/0", in_ready, busy, sad_valid); end
    feed_block(1'b0, 20, 0, pre_v, post_v);
    tests++; if (post_v !== 1'b1) begin fails++; $display("FAIL b2b_valid: got %b want 1", post_v); end
    tests++; if (sad_out !== SAD_W'(exp2)) begin fails++; $display("FAIL b2b_sad: got %0d want %0d", sad_out, exp2); end
    handshake(1'b0);
  endtask

  task automatic test_reset_mid_block();
    logic pre_v, post_v;
    int exp;
    fill_random();
    start = 1'b1; tick(); start = 1'b0;
    for (int b = 0; b < 7; b++) begin
      in_valid = 1'b1; drive_beat(b); tick();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0 || in_ready !== 1'b0 || sad_valid !== 1'b0) begin fails++; $display("FAIL midrst_flags: busy=%b in_ready=%b sad_valid=%b want 0/0/0", busy, in_ready, sad_valid); end
    tests++; if (sad_out !== '0) begin fails++; $display("FAIL midrst_sad_out: got %0d want 0", sad_out); end
    tick();
    rst = 1'b0;
    tick();
    fill_random();
    exp = model_sad();
    feed_block(1'b1, 10, 0, pre_v, post_v);
    tests++; if (post_v !== 1'b1 || sad_out !== SAD_W'(exp)) begin fails++; $display("FAIL midrst_fresh: got %0d/%b want %0d/1", sad_out, post_v, exp); end
    handshake(1'b0);
  endtask

  task automatic test_ignored_inputs();
    logic pre_v, post_v;
    int exp;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; cur_pix = $urandom; ref_pix = $urandom;
      tick();
      tests++; if (in_ready !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL idle_ignore: in_ready=%b busy=%b want 0/0", in_ready, busy); end
    end
    in_valid = 1'b0;
    fill_random();
    exp = model_sad();
    feed_block(1'b1, 30, 50, pre_v, post_v);
    tests++; if (pre_v !== 1'b0 || post_v !== 1'b1) begin fails++; $display("FAIL start_in_accum_count: pre=%b post=%b want 0/1", pre_v, post_v); end
    tests++; if (sad_out !== SAD_W'(exp)) begin fails++; $display("FAIL start_in_accum_sad: got %0d want %0d", sad_out, exp); end
    handshake(1'b0);
  endtask

  task automatic test_random_chain();
    logic pre_v, post_v;
    int exp;
    for (int n = 0; n < 4; n++) begin
      fill_random();
      exp = model_sad();
      feed_block(n == 0, $urandom_range(50), 20, pre_v, post_v);
      tests++; if (post_v !== 1'b1 || sad_out !== SAD_W'(exp)) begin fails++; $display("FAIL chain_sad[%0d]: got %0d/%b want %0d/1", n, sad_out, post_v, exp); end
      handshake(n != 3);
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL chain_idle: busy=%b want 0", busy); end
  endtask

`ifdef SAD_MIN_TRACK_EN
  task automatic test_min_track();
    logic pre_v, post_v;
    int tgt[5] = '{500, 300, 300, 700, 100};
    int mmin = (1 << SAD_W) - 1;
    int midx = 0;
    int cidx = 0;
    clear_min = 1'b1; tick(); clear_min = 1'b0;
    tests++; if (min_sad !== '1 || min_idx !== 8'd0) begin fails++; $display("FAIL min_clear0: got %0d/%0d want %0d/0", min_sad, min_idx, mmin); end
    for (int n = 0; n < 4; n++) begin
      fill_target(tgt[n]);
      feed_block(1'b1, 10, 0, pre_v, post_v);
      tests++; if (sad_out !== SAD_W'(model_sad())) begin fails++; $display("FAIL min_block[%0d]: got %0d want %0d", n, sad_out, model_sad()); end
      handshake(1'b0);
      if (model_sad() < mmin) begin mmin = model_sad(); midx = cidx; end
      cidx++;
      tests++; if (min_sad !== SAD_W'(mmin) || min_idx !== 8'(midx)) begin fails++; $display("FAIL min_track[%0d]: got %0d/%0d want %0d/%0d", n, min_sad, min_idx, mmin, midx); end
    end
    // Clear coinciding with a handshake of a smaller result: clear must win.
    fill_target(tgt[4]);
    feed_block(1'b1, 0, 0, pre_v, post_v);
    clear_min = 1'b1;
    handshake(1'b0);
    clear_min = 1'b0;
    tests++; if (min_sad !== '1 || min_idx !== 8'd0) begin fails++; $display("FAIL min_clear_wins: got %0d/%0d want all-ones/0", min_sad, min_idx); end
    fill_target(tgt[3]);
    feed_block(1'b1, 0, 0, pre_v, post_v);
    handshake(1'b0);
    tests++; if (min_sad !== SAD_W'(tgt[3]) || min_idx !== 8'd0) begin fails++; $display("FAIL min_after_clear: got %0d/%0d want %0d/0", min_sad, min_idx, tgt[3]); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_scale();
    test_gaps();
    test_hold_back_to_back();
    test_reset_mid_block();
    test_ignored_inputs();
    test_random_chain();
`ifdef SAD_MIN_TRACK_EN
    test_min_track();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
